mmio_bus_controller: RTL
========================

# mmio_bus_controller

Parametrised memory/IO bus controller between the single-cycle CPU core and data memory plus up to 63 peripheral channels. Replaces the purely combinational mem/IO steering with a stalling FSM: RAM accesses pass through in zero cycles; IO accesses use a per-channel request/ready handshake with timeout, and unmapped-address detection. Sticky error status is software-visible at a reserved address.

## Interface

Parameters:
- NUM_CH, 4, number of IO channels, 1..63
- DATA_W, 32, IO data width, 1..32; zero-extended to 32 bits toward the CPU
- TIMEOUT, 15, max REQ cycles before abort, 1..255

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_addr  in  32  byte address from ALU result
- cpu_rd  in  1  load request
- cpu_wr  in  1  store request
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data to register writeback
- cpu_stall  out  1  freezes PC and register writes while high
- mem_addr  out  32  equals cpu_addr
- mem_we  out  1  data memory write enable
- mem_wdata  out  32  equals cpu_wdata
- mem_rdata  in  32  data memory read data
- io_sel  out  NUM_CH  one-hot channel select, registered
- io_we  out  1  IO write strobe, registered
- io_addr  out  2  word offset in channel, registered
- io_wdata  out  DATA_W  IO write data, registered
- io_rdata  in  NUM_CH*DATA_W  channel k occupies [k*DATA_W +: DATA_W]
- io_ready  in  NUM_CH  per-channel completion
- err_irq  out  1  OR of sticky error bits

## Operation

- IO space: cpu_addr[31:10] == 22'h3FFFFF. Channel = cpu_addr[9:4], offset = cpu_addr[3:2]; cpu_addr[1:0] ignored.
- Status register: 0xFFFFFFFC (ch 63, offset 3). Read returns {30'b0, unmapped_err, timeout_err}; a write clears both bits.
- Access = cpu_rd | cpu_wr. If both are high, it is a write; cpu_rd is ignored.
- Non-IO access: mem_we = cpu_wr, cpu_rdata = mem_rdata, cpu_stall = 0, FSM untouched.
- FSM states IDLE, REQ, DONE:
  - IDLE, IO access to a mapped channel (< NUM_CH): cpu_stall=1. Latch io_sel, io_we, io_addr, io_wdata (cpu_wdata[DATA_W-1:0]); clear timer; go REQ.
  - IDLE, status access or unmapped channel: cpu_stall=1; go DONE. Unmapped: set unmapped_err, rdata_q=0, no io_sel pulse. Status write: clear errors.
  - REQ: cpu_stall=1; timer increments each cycle. When io_ready[ch]: rdata_q = zero-extended io_rdata slice, go DONE. Else if timer == TIMEOUT-1: set timeout_err, rdata_q=0, go DONE.
  - DONE: io_sel, io_we = 0; cpu_stall=0; cpu_rdata=rdata_q; go IDLE unconditionally.
- io_ready of non-selected channels is ignored. io_ready in IDLE/DONE is ignored.
- mem_we is forced 0 for every IO-space address.

## Timing

- Reset: state IDLE. io_sel, io_we, io_addr, io_wdata, rdata_q, timer, and both error bits are 0. err_irq=0; cpu_stall=0 unless an IO access is presented.
- cpu_stall is combinational from state and the cpu_addr decode. io_* outputs change only on clk edges.
- Mapped IO latency: ready sampled on the first REQ edge gives 3 cycles (IDLE, REQ, DONE), stall high for 2. Each extra not-ready cycle adds 1.
- Timeout: REQ lasts exactly TIMEOUT cycles, then DONE.
- Unmapped or status access: 2 cycles, stall high for 1.
- Error bits set on the edge entering DONE; err_irq rises the same edge.
- A status write in the same cycle as a new error-setting event is impossible (single outstanding access).
- Reset asserted mid-REQ: immediate return to IDLE, io_sel and io_we drop asynchronously, error bits are lost.

## Test plan

- Reset, then lw from 0x00000010 with mem_rdata=0x12345678: cpu_stall=0, cpu_rdata=0x12345678 the same cycle, io_sel=0.
- sw to 0xFFFFFC14 with cpu_wdata=0xA5, io_ready[1] high immediately: io_sel=4'b0010, io_we=1, io_addr=1 for one cycle; stall 2 cycles; mem_we=0 throughout.
- lw from 0xFFFFFC20, io_ready[2] raised after 4 REQ cycles with slice 0xBEEF: stall 5 cycles, cpu_rdata=0x0000BEEF in DONE.
- lw from 0xFFFFFC30, io_ready never high, TIMEOUT=15: DONE after 15 REQ cycles, cpu_rdata=0, err_irq=1. Then lw 0xFFFFFFFC returns 0x1; sw 0xFFFFFFFC clears it, so err_irq=0.
- lw from 0xFFFFFC50 with NUM_CH=4: no io_sel pulse, stall 1 cycle, cpu_rdata=0. Status read returns 0x2.
- rst pulsed during REQ: io_sel=0 and state IDLE immediately; a subsequent access behaves as after a fresh reset.

Source files
------------

// File: rtl/mmio_bus_controller.sv
// CPU data-side bus controller: zero-wait RAM path plus a stalling
// request/ready IO path with timeout, unmapped detection and sticky status.
module mmio_bus_controller #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              cpu_addr,
  input  logic                     cpu_rd,
  input  logic                     cpu_wr,
  input  logic [31:0]              cpu_wdata,
  output logic [31:0]              cpu_rdata,
  output logic                     cpu_stall,
  output logic [31:0]              mem_addr,
  output logic                     mem_we,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata,
  output logic [NUM_CH-1:0]        io_sel,
  output logic                     io_we,
  output logic [1:0]               io_addr,
  output logic [DATA_W-1:0]        io_wdata,
  input  logic [NUM_CH*DATA_W-1:0] io_rdata,
  input  logic [NUM_CH-1:0]        io_ready,
  output logic                     err_irq
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t              state, state_nx;
  logic                is_io, is_status, mapped, io_req;
  logic                ready_hit, timed_out;
  logic [5:0]          ch;
  logic [NUM_CH-1:0]   sel_dec;
  logic [DATA_W-1:0]   slice;
  logic [7:0]          timer;
  logic [31:0]         rdata_q;
  logic                to_err, um_err;
  logic                unused_ok;

  assign is_io     = cpu_addr[31:10] == 22'h3FFFFF;
  assign ch        = cpu_addr[9:4];
  assign is_status = is_io && (cpu_addr[9:2] == 8'hFF);
  assign mapped    = int'(ch) < NUM_CH;
  assign io_req    = is_io && (cpu_rd || cpu_wr);
  assign timed_out = timer == 8'(TIMEOUT - 1);
  assign unused_ok = ^{cpu_addr[1:0], cpu_wdata};

  assign mem_addr  = cpu_addr;
  assign mem_wdata = cpu_wdata;
  assign err_irq   = to_err | um_err;

  // io_sel is one-hot while in REQ, so it steers ready and read data
  always_comb begin
    sel_dec   = '0;
    slice     = '0;
    ready_hit = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      sel_dec[k] = ch == 6'(k);
      if (io_sel[k]) begin
        slice     = slice | io_rdata[k*DATA_W +: DATA_W];
        ready_hit = ready_hit | io_ready[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (io_req)
              state_nx = (mapped && !is_status) ? REQ : DONE;
      REQ:  if (ready_hit || timed_out)
              state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cpu_stall = io_req && (state != DONE);
    mem_we    = cpu_wr && !is_io;
    cpu_rdata = is_io ? rdata_q : mem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_sel   <= '0;
      io_we    <= 1'b0;
      io_addr  <= 2'd0;
      io_wdata <= '0;
      rdata_q  <= 32'd0;
      timer    <= 8'd0;
      to_err   <= 1'b0;
      um_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          timer <= 8'd0;
          if (io_req) begin
            if (is_status) begin
              if (cpu_wr) begin
                to_err  <= 1'b0;
                um_err  <= 1'b0;
                rdata_q <= 32'd0;
              end else begin
                rdata_q <= {30'd0, um_err, to_err};
              end
            end else if (mapped) begin
              io_sel   <= sel_dec;
              io_we    <= cpu_wr;
              io_addr  <= cpu_addr[3:2];
              io_wdata <= cpu_wdata[DATA_W-1:0];
            end else begin
              um_err  <= 1'b1;
              rdata_q <= 32'd0;
            end
          end
        end
        REQ: begin
          timer <= timer + 8'd1;
          if (ready_hit) begin
            rdata_q <= 32'(slice);
            io_sel  <= '0;
            io_we   <= 1'b0;
          end else if (timed_out) begin
            to_err  <= 1'b1;
            rdata_q <= 32'd0;
            io_sel  <= '0;
            io_we   <= 1'b0;
          end
        end
        DONE: begin
          io_sel <= '0;
          io_we  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
